instr_mem_loader: RTL and testbench

- Writer side of the instruction memory. The CPU core only reads instruction memory; this block fills it before the core runs.
- Accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit words.
- Writes each word to consecutive word-aligned instruction memory addresses.
- After the last write, raises the start strobe consumed by the CPU's `start_i`.

---
 rtl/instr_mem_loader.sv | 128 ++++++++++++
 tb/tb_instr_mem_loader.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loader.sv
// Instruction memory loader: 2-byte word count header, then LSB-first bytes packed into 32-bit writes.
// Latency: the write pulse follows the 4th byte of a word by one cycle; start_o rises the cycle after the last write.
// Backpressure: ready is a pure state decode, low during the write cycle and in the terminal DONE/ERROR states.
module instr_mem_loader #(
  parameter int DEPTH_LOG2 = 8,
  parameter int ADDR_W     = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  byte_valid_i,
  input  logic [7:0]            byte_data_i,
  output logic                  byte_ready_o,
  output logic                  mem_we_o,
  output logic [ADDR_W-1:0]     mem_addr_o,
  output logic [31:0]           mem_data_o,
  output logic [DEPTH_LOG2:0]   words_loaded_o,
  output logic                  start_o,
  output logic                  err_o
);

  localparam int          CNT_W    = DEPTH_LOG2 + 1;
  localparam logic [16:0] CAPACITY = 17'(1) << DEPTH_LOG2;

  typedef enum logic [2:0] {
    CNT_LO,
    CNT_HI,
    DATA,
    WRITE,
    DONE,
    ERROR
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [15:0]         n_q;
  logic [1:0]          byte_idx_q;
  logic [23:0]         asm_q;
  logic [31:0]         mem_data_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [CNT_W-1:0]    words_q;
  logic [CNT_W-1:0]    words_inc;
  logic [15:0]         n_full;
  logic                accept;

  assign words_inc = words_q + CNT_W'(1);
  assign n_full    = {byte_data_i, n_q[7:0]};
  assign accept    = byte_valid_i & byte_ready_o;

  always_comb begin
    state_d      = state_q;
    byte_ready_o = 1'b0;
    mem_we_o     = 1'b0;
    start_o      = 1'b0;
    err_o        = 1'b0;
    case (state_q)
      CNT_LO: begin
        byte_ready_o = 1'b1;
        if (byte_valid_i) state_d = CNT_HI;
      end
      CNT_HI: begin
        byte_ready_o = 1'b1;
        if (byte_valid_i) begin
          if (n_full == 16'd0)                 state_d = DONE;
          else if ({1'b0, n_full} > CAPACITY)  state_d = ERROR;
          else                                 state_d = DATA;
        end
      end
      DATA: begin
        byte_ready_o = 1'b1;
        if (byte_valid_i && byte_idx_q == 2'd3) state_d = WRITE;
      end
      WRITE: begin
        mem_we_o = 1'b1;
        // Compare at 17 bits so a full-capacity count cannot alias to zero.
        if (17'(words_inc) == 17'(n_q)) state_d = DONE;
        else                            state_d = DATA;
      end
      DONE:    start_o = 1'b1;
      ERROR:   err_o   = 1'b1;
      default: state_d = CNT_LO;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= CNT_LO;
      n_q        <= '0;
      byte_idx_q <= '0;
      asm_q      <= '0;
      mem_data_q <= '0;
      mem_addr_q <= '0;
      words_q    <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        CNT_LO: if (accept) n_q[7:0] <= byte_data_i;
        CNT_HI: begin
          if (accept) begin
            n_q[15:8]  <= byte_data_i;
            byte_idx_q <= 2'd0;
          end
        end
        DATA: begin
          if (accept) begin
            byte_idx_q <= byte_idx_q + 2'd1;
            case (byte_idx_q)
              2'd0: asm_q[7:0]   <= byte_data_i;
              2'd1: asm_q[15:8]  <= byte_data_i;
              2'd2: asm_q[23:16] <= byte_data_i;
              default: begin
                // Word and address are registered here so they hold steady through WRITE.
                mem_data_q <= {byte_data_i, asm_q};
                mem_addr_q <= ADDR_W'(words_q) << 2;
              end
            endcase
          end
        end
        WRITE:   words_q <= words_inc;
        default: ;
      endcase
    end
  end

  assign mem_data_o     = mem_data_q;
  assign mem_addr_o     = mem_addr_q;
  assign words_loaded_o = words_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed and randomized streams for instr_mem_loader, checked against a word-list model built from the byte stream.
module tb_instr_mem_loader;

  localparam int DEPTH_LOG2 = 8;
  localparam int ADDR_W     = 32;

  logic                clk_i = 1'b0;
  logic                rst_i;
  logic                byte_valid_i;
  logic [7:0]          byte_data_i;
  logic                byte_ready_o;
  logic                mem_we_o;
  logic [ADDR_W-1:0]   mem_addr_o;
  logic [31:0]         mem_data_o;
  logic [DEPTH_LOG2:0] words_loaded_o;
  logic                start_o;
  logic                err_o;

  instr_mem_loader #(.DEPTH_LOG2(DEPTH_LOG2), .ADDR_W(ADDR_W)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .byte_valid_i   (byte_valid_i),
    .byte_data_i    (byte_data_i),
    .byte_ready_o   (byte_ready_o),
    .mem_we_o       (mem_we_o),
    .mem_addr_o     (mem_addr_o),
    .mem_data_o     (mem_data_o),
    .words_loaded_o (words_loaded_o),
    .start_o        (start_o),
    .err_o          (err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  int         checks = 0;
  int         errors = 0;
  int         cyc    = 0;
  wr_t        wr_q[$];
  wr_t        exp_q[$];
  logic [7:0] pay_q[$];

  always @(posedge clk_i) cyc <= cyc + 1;

  always @(negedge clk_i)
    if (mem_we_o === 1'b1) wr_q.push_back({mem_addr_o, mem_data_o});

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    int w = 0;
    repeat (gap) begin
      byte_valid_i = 1'b0;
      tick();
    end
    byte_valid_i = 1'b1;
    byte_data_i  = b;
    @(negedge clk_i);
    while (byte_ready_o !== 1'b1 && w < 20) begin
      @(negedge clk_i);
      w++;
    end
    if (byte_ready_o !== 1'b1) check("accept_timeout", 64'(byte_ready_o), 64'd1);
    tick();
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_ready"}, 64'(byte_ready_o),   64'd1);
    check({pfx, "_we"},    64'(mem_we_o),       64'd0);
    check({pfx, "_addr"},  64'(mem_addr_o),     64'd0);
    check({pfx, "_data"},  64'(mem_data_o),     64'd0);
    check({pfx, "_words"}, 64'(words_loaded_o), 64'd0);
    check({pfx, "_start"}, 64'(start_o),        64'd0);
    check({pfx, "_err"},   64'(err_o),          64'd0);
  endtask

  // Expected writes: word i lives at byte address 4*i and packs payload bytes 4i..4i+3 LSB first.
  task automatic build_model(input int n);
    for (int i = 0; i < n; i++)
      exp_q.push_back({32'(i * 4), pay_q[4*i+3], pay_q[4*i+2], pay_q[4*i+1], pay_q[4*i]});
  endtask

  task automatic check_writes(input string tag);
    check({tag, "_wr_count"}, 64'(wr_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < wr_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s_wr%0d", tag, i), wr_q[i], exp_q[i]);
    wr_q.delete();
    exp_q.delete();
    pay_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0;
    logic [7:0] b;

    rst_i        = 1'b1;
    byte_valid_i = 1'b0;
    byte_data_i  = 8'h00;
    repeat (2) tick();
    rst_i = 1'b0;
    check_reset_outputs("rst");

    // Two words with valid held high.
    wr_q.delete();
    send(8'h02, 0); send(8'h00, 0);
    send(8'h13, 0); send(8'h05, 0); send(8'h10, 0); send(8'h00, 0);
    check("t1_we0",   64'(mem_we_o),   64'd1);
    check("t1_addr0", 64'(mem_addr_o), 64'd0);
    check("t1_data0", 64'(mem_data_o), 64'h0010_0513);
    c0 = cyc;
    send(8'h93, 0); send(8'h05, 0); send(8'h20, 0); send(8'h00, 0);
    check("t1_we1",         64'(mem_we_o),   64'd1);
    check("t1_addr1",       64'(mem_addr_o), 64'd4);
    check("t1_data1",       64'(mem_data_o), 64'h0020_0593);
    check("t1_word_cycles", 64'(cyc - c0),   64'd5);
    check("t1_start_early", 64'(start_o),    64'd0);
    tick();
    check("t1_start", 64'(start_o),        64'd1);
    check("t1_words", 64'(words_loaded_o), 64'd2);
    check("t1_ready", 64'(byte_ready_o),   64'd0);
    check("t1_we_off", 64'(mem_we_o),      64'd0);
    repeat (3) tick();
    check("t1_words_hold", 64'(words_loaded_o), 64'd2);
    pay_q = '{8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
    build_model(2);
    check_writes("t1");

    // Empty program.
    do_reset();
    byte_valid_i = 1'b0;
    send(8'h00, 0);
    check("t2_start_hdr", 64'(start_o), 64'd0);
    send(8'h00, 0);
    check("t2_start", 64'(start_o), 64'd1);
    check("t2_ready", 64'(byte_ready_o), 64'd0);
    tick();
    check("t2_words", 64'(words_loaded_o), 64'd0);
    check_writes("t2");

    // Oversized count: 257 words.
    do_reset();
    byte_valid_i = 1'b0;
    send(8'h01, 0); send(8'h01, 0);
    check("t3_err",   64'(err_o),        64'd1);
    check("t3_start", 64'(start_o),      64'd0);
    check("t3_ready", 64'(byte_ready_o), 64'd0);
    byte_valid_i = 1'b1;
    byte_data_i  = 8'h55;
    repeat (4) tick();
    check("t3_ready_hold", 64'(byte_ready_o),   64'd0);
    check("t3_err_hold",   64'(err_o),          64'd1);
    check("t3_words",      64'(words_loaded_o), 64'd0);
    check_writes("t3");

    // One word with three idle cycles before every payload byte.
    do_reset();
    byte_valid_i = 1'b0;
    send(8'h01, 0); send(8'h00, 0);
    pay_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    for (int i = 0; i < 4; i++) begin
      byte_valid_i = 1'b0;
      repeat (3) begin
        tick();
        check($sformatf("t4_gap_ready%0d", i), 64'(byte_ready_o), 64'd1);
        check($sformatf("t4_gap_we%0d", i),    64'(mem_we_o),     64'd0);
      end
      send(pay_q[i], 0);
    end
    check("t4_we",   64'(mem_we_o),   64'd1);
    check("t4_addr", 64'(mem_addr_o), 64'd0);
    check("t4_data", 64'(mem_data_o), 64'hDDCC_BBAA);
    byte_valid_i = 1'b0;
    tick();
    check("t4_start", 64'(start_o), 64'd1);
    build_model(1);
    check_writes("t4");

    // Reset mid-stream, with a byte offered on the reset edge, then a fresh stream.
    do_reset();
    byte_valid_i = 1'b0;
    send(8'h03, 0); send(8'h00, 0);
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom_range(0, 255));
      pay_q.push_back(b);
      send(b, 0);
    end
    check("t5_words_pre", 64'(words_loaded_o), 64'd1);
    byte_valid_i = 1'b1;
    byte_data_i  = 8'h77;
    rst_i        = 1'b1;
    tick();
    rst_i        = 1'b0;
    byte_valid_i = 1'b0;
    check_reset_outputs("t5_rst");
    build_model(1);
    check_writes("t5_pre");
    send(8'h01, 0); send(8'h00, 0);
    send(8'hEF, 0); send(8'hBE, 0); send(8'hAD, 0); send(8'hDE, 0);
    check("t5_we",   64'(mem_we_o),   64'd1);
    check("t5_addr", 64'(mem_addr_o), 64'd0);
    check("t5_data", 64'(mem_data_o), 64'hDEAD_BEEF);
    byte_valid_i = 1'b0;
    tick();
    check("t5_start", 64'(start_o), 64'd1);
    pay_q = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    build_model(1);
    check_writes("t5");

    // Full capacity with random bytes and random idle gaps.
    do_reset();
    byte_valid_i = 1'b0;
    send(8'h00, 0); send(8'h01, 0);
    for (int i = 0; i < 1024; i++) begin
      b = 8'($urandom_range(0, 255));
      pay_q.push_back(b);
      send(b, int'($urandom_range(0, 2)));
    end
    byte_valid_i = 1'b0;
    tick();
    check("t6_words", 64'(words_loaded_o), 64'd256);
    check("t6_start", 64'(start_o),        64'd1);
    check("t6_err",   64'(err_o),          64'd0);
    build_model(256);
    check_writes("t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
